// File: rtl/msg_validator_fsm.sv
// msg_validator_fsm
//
// Sits after the RC4 decryption stage. When the master raises start, it scans
// the decrypted message one byte per cycle and accepts only lowercase letters
// and space, stopping at the first illegal byte. A fully legal message is
// copied into the result RAM with a three-cycle write handshake per byte
// (setup / write / disable). The verdict is then presented on done/valid/bad_index
// until the master drops start.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high; every output returns to 0
//   start           request level from the master
//   decrypted_input MSG_DEP bytes of plaintext; held stable from start until done
//   address_out     result RAM address
//   data_out        result RAM write data
//   enable_write    result RAM write enable; one-cycle pulse per byte
//   valid           1 = whole message legal (meaningful while done=1)
//   bad_index       index of the first illegal byte; 0 when valid=1
//   done            verdict ready; held until start drops
//
// All outputs are registers. Each output takes the value belonging to the
// state being entered, so address/data are already settled in COPY_SETUP and
// stay put through COPY_DIS around the single-cycle write pulse.

module msg_validator_fsm #(
  parameter int unsigned              MSG_DEP    = 32,
  parameter int unsigned              MSG_WIDTH  = 8,
  parameter logic [MSG_WIDTH-1:0]     LOW_CHAR   = 8'h61,
  parameter logic [MSG_WIDTH-1:0]     HIGH_CHAR  = 8'h7A,
  parameter logic [MSG_WIDTH-1:0]     SPACE_CHAR = 8'h20,
  localparam int unsigned             KW         = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [MSG_DEP-1:0][MSG_WIDTH-1:0]   decrypted_input,
  output logic [KW-1:0]                       address_out,
  output logic [MSG_WIDTH-1:0]                data_out,
  output logic                                enable_write,
  output logic                                valid,
  output logic [KW-1:0]                       bad_index,
  output logic                                done
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StCopySetup,
    StCopyWrite,
    StCopyDis,
    StDone
  } state_e;

  state_e              state;
  logic [KW-1:0]       k;
  // start is registered before IDLE acts on it: the edge that samples start=1
  // arms the launch, and the following edge enters CHECK at byte 0.
  logic                start_q;

  logic [MSG_WIDTH-1:0] cur_byte;
  logic                 cur_legal;
  logic                 k_last;
  logic [KW-1:0]        k_inc;

  always_comb begin
    cur_byte  = decrypted_input[k];
    // Unsigned comparisons over the full byte width.
    cur_legal = ((cur_byte >= LOW_CHAR) && (cur_byte <= HIGH_CHAR)) ||
                (cur_byte == SPACE_CHAR);
    // Bound is tested before incrementing, so k never wraps.
    k_last    = (k == KW'(MSG_DEP - 1));
    k_inc     = k + KW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      k            <= '0;
      start_q      <= 1'b0;
      address_out  <= '0;
      data_out     <= '0;
      enable_write <= 1'b0;
      valid        <= 1'b0;
      bad_index    <= '0;
      done         <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        StIdle: begin
          k            <= '0;
          valid        <= 1'b0;
          bad_index    <= '0;
          done         <= 1'b0;
          enable_write <= 1'b0;
          if (start_q) begin
            state <= StCheck;
          end
        end

        StCheck: begin
          if (!cur_legal) begin
            bad_index <= k;
            valid     <= 1'b0;
            done      <= 1'b1;
            state     <= StDone;
          end else if (k_last) begin
            // Whole message legal: load byte 0 for the copy on the way in.
            valid        <= 1'b1;
            k            <= '0;
            address_out  <= '0;
            data_out     <= decrypted_input[0];
            enable_write <= 1'b0;
            state        <= StCopySetup;
          end else begin
            k <= k_inc;
          end
        end

        StCopySetup: begin
          enable_write <= 1'b1;
          state        <= StCopyWrite;
        end

        StCopyWrite: begin
          enable_write <= 1'b0;
          state        <= StCopyDis;
        end

        StCopyDis: begin
          enable_write <= 1'b0;
          if (k_last) begin
            done  <= 1'b1;
            state <= StDone;
          end else begin
            k           <= k_inc;
            address_out <= k_inc;
            data_out    <= decrypted_input[k_inc];
            state       <= StCopySetup;
          end
        end

        StDone: begin
          // Master acknowledges by dropping start; verdict clears on the same edge.
          if (!start) begin
            k         <= '0;
            valid     <= 1'b0;
            bad_index <= '0;
            done      <= 1'b0;
            state     <= StIdle;
          end
        end

        default: begin
          enable_write <= 1'b0;
          state        <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_validator_fsm.sv
// Scoreboard bench for msg_validator_fsm: the driver pushes expected RAM
// writes and the expected verdict (with the edge on which done must rise);
// a negedge monitor pops and compares whenever the DUT writes or raises done.

module tb_msg_validator_fsm;

  localparam int DEP = 32;

  typedef struct {
    bit is_write;
    int addr;
    int data;
    int vld;
    int bad;
    int done_edge;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [DEP-1:0][7:0]  din;
  logic [4:0]           address_out;
  logic [7:0]           data_out;
  logic                 enable_write;
  logic                 valid;
  logic [4:0]           bad_index;
  logic                 done;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  msg_validator_fsm dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .decrypted_input (din),
    .address_out     (address_out),
    .data_out        (data_out),
    .enable_write    (enable_write),
    .valid           (valid),
    .bad_index       (bad_index),
    .done            (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: at a negedge, cyc equals the index of the last rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  function automatic bit legal(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7a));
  endfunction

  // ---------------------------------------------------------------- monitor
  initial begin
    logic       done_prev = 1'b0;
    logic       ew_prev   = 1'b0;
    logic [4:0] addr_prev = '0;
    logic [7:0] data_prev = '0;
    logic [4:0] la        = '0;
    logic [7:0] ld        = '0;
    bit         chk_next  = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      // Cycle after a write (COPY_DIS): pulse gone, address and data unchanged.
      if (chk_next) begin
        chk_next = 1'b0;
        if (reset !== 1'b1) begin
          check("write_pulse_fall", enable_write, 0);
          check("addr_hold_after", address_out, la);
          check("data_hold_after", data_out, ld);
        end
      end
      if (enable_write === 1'b1) begin
        check("write_pulse_rise", ew_prev, 0);
        check("addr_setup_before", addr_prev, address_out);
        check("data_setup_before", data_prev, data_out);
        check("write_expected", (q.size() != 0 && q[0].is_write), 1);
        if (q.size() != 0 && q[0].is_write) begin
          e = q.pop_front();
          check("write_addr", address_out, e.addr);
          check("write_data", data_out, e.data);
        end
        chk_next = 1'b1;
        la = address_out;
        ld = data_out;
      end
      if (done === 1'b1 && done_prev !== 1'b1) begin
        check("verdict_expected", (q.size() != 0 && !q[0].is_write), 1);
        if (q.size() != 0 && !q[0].is_write) begin
          e = q.pop_front();
          check("verdict_valid", valid, e.vld);
          check("verdict_bad_index", bad_index, e.bad);
          check("done_edge", cyc, e.done_edge);
        end
      end
      done_prev = done;
      ew_prev   = enable_write;
      addr_prev = address_out;
      data_prev = data_out;
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic run_msg(input logic [DEP-1:0][7:0] msg, input int hold, input string tag);
    int   first_bad = -1;
    int   edge0;
    bit   got = 1'b0;
    bit   held = 1'b1;
    exp_t e;
    for (int i = 0; i < DEP; i++) begin
      if (first_bad < 0 && !legal(msg[i])) first_bad = i;
    end
    @(negedge clk);
    din   = msg;
    start = 1'b1;
    edge0 = cyc + 1;
    if (first_bad < 0) begin
      for (int b = 0; b < DEP; b++) begin
        e = '{is_write: 1'b1, addr: b, data: int'(msg[b]), vld: 0, bad: 0, done_edge: 0};
        q.push_back(e);
      end
      e = '{is_write: 1'b0, addr: 0, data: 0, vld: 1, bad: 0, done_edge: edge0 + 4 * DEP + 1};
    end else begin
      e = '{is_write: 1'b0, addr: 0, data: 0, vld: 0, bad: first_bad,
            done_edge: edge0 + first_bad + 2};
    end
    q.push_back(e);
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1);
    repeat (hold) begin
      @(negedge clk);
      if (done !== 1'b1) held = 1'b0;
    end
    if (hold > 0) check({tag, "_done_held"}, held, 1);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_clear"}, done, 0);
    check({tag, "_queue_drained"}, q.size(), 0);
  endtask

  initial begin
    logic [DEP-1:0][7:0] m;
    logic [DEP-1:0][7:0] vary;
    logic [7:0]          bvals [8];
    exp_t                e;
    int                  edge0;

    bvals = '{8'h20, 8'h61, 8'h7a, 8'h1f, 8'h60, 8'h7b, 8'h21, 8'hff};
    for (int i = 0; i < DEP; i++) begin
      vary[i] = (i % 5 == 4) ? 8'h20 : 8'(8'h61 + (i % 26));
    end

    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_bad_index", bad_index, 0);
    check("rst_enable_write", enable_write, 0);
    check("rst_address", address_out, 0);
    check("rst_data", data_out, 0);
    reset = 1'b0;

    // All 'a': valid, 32 writes, done after edge 129.
    for (int i = 0; i < DEP; i++) m[i] = 8'h61;
    run_msg(m, 0, "all_a");

    // First byte 'A' fails immediately.
    m[0] = 8'h41;
    run_msg(m, 0, "byte0_upper");

    // Byte 17 = '{' among spaces.
    for (int i = 0; i < DEP; i++) m[i] = 8'h20;
    m[17] = 8'h7b;
    run_msg(m, 0, "byte17_brace");

    // Boundary characters in the last byte.
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < DEP; i++) m[i] = 8'h6d;
      m[DEP-1] = bvals[j];
      run_msg(m, 0, $sformatf("boundary_%02h", bvals[j]));
    end

    // Reset during COPY_WRITE of byte 5 (entered at edge0 + DEP + 2 + 3*5).
    @(negedge clk);
    din   = vary;
    start = 1'b1;
    edge0 = cyc + 1;
    for (int b = 0; b <= 5; b++) begin
      e = '{is_write: 1'b1, addr: b, data: int'(vary[b]), vld: 0, bad: 0, done_edge: 0};
      q.push_back(e);
    end
    while (cyc < edge0 + DEP + 2 + 15) @(negedge clk);
    check("pre_reset_enable_write", enable_write, 1);
    check("pre_reset_address", address_out, 5);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("mid_write_reset_enable_write", enable_write, 0);
    check("mid_write_reset_done", done, 0);
    check("mid_write_reset_valid", valid, 0);
    check("mid_write_reset_address", address_out, 0);
    check("mid_write_reset_data", data_out, 0);
    check("mid_write_reset_queue", q.size(), 0);
    reset = 1'b0;

    // Fresh scan after reset completes normally.
    run_msg(vary, 0, "after_reset");

    // Hold start through DONE, then a new invalid message replaces the verdict.
    for (int i = 0; i < DEP; i++) m[i] = 8'h7a;
    run_msg(m, 12, "held_done");
    m[9] = 8'h60;
    run_msg(m, 0, "new_verdict");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
